// File: rtl/seq_gen_sreg.sv
// rtl/seq_gen_sreg.sv - serial pattern generator with 6-bit transmit history; optional parity slot via SEQ_GEN_PARITY_EN
module seq_gen_sreg #(
    parameter int MAX_LEN = 32,
    parameter int PTR_W   = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [MAX_LEN-1:0] pat,
    input  logic [PTR_W-1:0]   len,
    input  logic               start,
    input  logic               stop,
    input  logic               repeat_en,
    output logic               dout,
    output logic               dvalid,
    output logic               busy,
    output logic               done,
    output logic [PTR_W-1:0]   ptr,
    output logic               par_flag,
    output logic [5:0]         sreg6
);
    localparam logic [PTR_W-1:0] LP_MAX_LEN = PTR_W'(MAX_LEN);

`ifdef SEQ_GEN_PARITY_EN
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAR} state_t;
`else
    typedef enum logic {S_IDLE, S_RUN} state_t;
`endif

    state_t             r_state;
    state_t             w_state_nx;
    logic [MAX_LEN-1:0] r_pat;
    logic [MAX_LEN-1:0] w_pat_nx;
    logic [PTR_W-1:0]   r_len;
    logic [PTR_W-1:0]   w_len_nx;
    logic [PTR_W-1:0]   r_ptr;
    logic [PTR_W-1:0]   w_ptr_nx;
    logic [PTR_W-1:0]   w_len_in;
    logic [PTR_W-1:0]   w_len_last;
    logic               r_dout;
    logic               w_dout_nx;
    logic               r_dvalid;
    logic               r_busy;
    logic               r_done;
    logic               w_done_nx;
    logic               r_par_flag;
    logic               w_par_flag_nx;
    logic [5:0]         r_sreg6;

    assign w_len_in   = (len > LP_MAX_LEN) ? LP_MAX_LEN : len;
    assign w_len_last = r_len - PTR_W'(1);

`ifdef SEQ_GEN_PARITY_EN
    logic w_parity;

    // Even parity over the active part of the held pattern
    always_comb begin
        w_parity = 1'b0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if (PTR_W'(i) < r_len) begin
                w_parity = w_parity ^ r_pat[i];
            end
        end
    end
`endif

    // Next-state, pointer and next-output decode
    always_comb begin
        w_state_nx    = r_state;
        w_pat_nx      = r_pat;
        w_len_nx      = r_len;
        w_ptr_nx      = r_ptr;
        w_done_nx     = 1'b0;
        w_dout_nx     = 1'b0;
        w_par_flag_nx = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_ptr_nx = '0;
                if (load) begin
                    w_pat_nx = pat;
                    w_len_nx = w_len_in;
                end
                if (start && (w_len_nx != '0)) begin
                    w_state_nx = S_RUN;
                end
            end
            S_RUN: begin
                if (stop) begin
                    w_state_nx = S_IDLE;
                    w_ptr_nx   = '0;
                end else if (r_ptr == w_len_last) begin
`ifdef SEQ_GEN_PARITY_EN
                    w_state_nx = S_PAR;
`else
                    w_ptr_nx = '0;
                    if (!repeat_en) begin
                        w_state_nx = S_IDLE;
                        w_done_nx  = 1'b1;
                    end
`endif
                end else begin
                    w_ptr_nx = r_ptr + PTR_W'(1);
                end
            end
`ifdef SEQ_GEN_PARITY_EN
            S_PAR: begin
                w_ptr_nx = '0;
                if (stop) begin
                    w_state_nx = S_IDLE;
                end else if (repeat_en) begin
                    w_state_nx = S_RUN;
                end else begin
                    w_state_nx = S_IDLE;
                    w_done_nx  = 1'b1;
                end
            end
`endif
            default: begin
                w_state_nx = S_IDLE;
                w_ptr_nx   = '0;
            end
        endcase

        // Outputs are registered, so the bit for the next cycle is picked from next-state values
        if (w_state_nx == S_RUN) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                if (PTR_W'(i) == w_ptr_nx) begin
                    w_dout_nx = w_pat_nx[i];
                end
            end
        end
`ifdef SEQ_GEN_PARITY_EN
        if (w_state_nx == S_PAR) begin
            w_dout_nx     = w_parity;
            w_par_flag_nx = 1'b1;
        end
`endif
    end

    // State, pattern and registered output update
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_pat      <= '0;
            r_len      <= '0;
            r_ptr      <= '0;
            r_dout     <= 1'b0;
            r_dvalid   <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_par_flag <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_pat      <= w_pat_nx;
            r_len      <= w_len_nx;
            r_ptr      <= w_ptr_nx;
            r_dout     <= w_dout_nx;
            r_dvalid   <= (w_state_nx != S_IDLE);
            r_busy     <= (w_state_nx != S_IDLE);
            r_done     <= w_done_nx;
            r_par_flag <= w_par_flag_nx;
        end
    end

    // History of transmitted bits, newest in bit 0; frozen while idle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sreg6 <= '0;
        end else if (r_dvalid) begin
            r_sreg6 <= {r_sreg6[4:0], r_dout};
        end
    end

    assign dout     = r_dout;
    assign dvalid   = r_dvalid;
    assign busy     = r_busy;
    assign done     = r_done;
    assign ptr      = r_ptr;
    assign par_flag = r_par_flag;
    assign sreg6    = r_sreg6;

endmodule

// File: tb/tb_seq_gen_sreg.sv
// tb/tb_seq_gen_sreg.sv - scoreboard bench for seq_gen_sreg
module tb_seq_gen_sreg;
    localparam int MAX_LEN = 32;
    localparam int PTR_W   = 6;

    logic               clk = 1'b0;
    logic               rst;
    logic               load;
    logic [MAX_LEN-1:0] pat;
    logic [PTR_W-1:0]   len;
    logic               start;
    logic               stop;
    logic               repeat_en;
    logic               dout;
    logic               dvalid;
    logic               busy;
    logic               done;
    logic [PTR_W-1:0]   ptr;
    logic               par_flag;
    logic [5:0]         sreg6;

    seq_gen_sreg #(.MAX_LEN(MAX_LEN), .PTR_W(PTR_W)) u_dut (
        .clk(clk), .rst(rst), .load(load), .pat(pat), .len(len),
        .start(start), .stop(stop), .repeat_en(repeat_en),
        .dout(dout), .dvalid(dvalid), .busy(busy), .done(done),
        .ptr(ptr), .par_flag(par_flag), .sreg6(sreg6)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit       is_done;
        bit       b;
        int       p;
        bit       pf;
        logic [5:0] s6;
        int       cyc;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic chk(input bit ok, input string name, input string act, input string req);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %s, required %s", name, act, req);
    endtask

    // Reference model: a transmission is a frame of bits (pattern, then optional parity) replayed pass after pass
    bit         m_busy = 1'b0;
    int         m_idx  = 0;
    logic [31:0] m_pat = '0;
    int         m_len  = 0;
    bit         m_fbit[$];
    int         m_fptr[$];
    bit         m_fpar[$];
    bit         m_hist[$];

    task automatic build_frame();
        logic [63:0] mask;
        m_fbit.delete(); m_fptr.delete(); m_fpar.delete();
        for (int i = 0; i < m_len; i++) begin
            m_fbit.push_back(m_pat[i]); m_fptr.push_back(i); m_fpar.push_back(1'b0);
        end
`ifdef SEQ_GEN_PARITY_EN
        mask = (64'd1 << m_len) - 64'd1;
        m_fbit.push_back(bit'($countones({32'd0, m_pat} & mask) % 2));
        m_fptr.push_back(m_len - 1);
        m_fpar.push_back(1'b1);
`endif
    endtask

    task automatic emit(input int tag);
        exp_t e;
        e.is_done = 1'b0;
        e.b   = m_fbit[m_idx];
        e.p   = m_fptr[m_idx];
        e.pf  = m_fpar[m_idx];
        e.s6  = '0;
        for (int k = 0; k < m_hist.size(); k++) e.s6[k] = m_hist[m_hist.size() - 1 - k];
        e.cyc = tag;
        sb.push_back(e);
        m_hist.push_back(e.b);
        if (m_hist.size() > 6) void'(m_hist.pop_front());
    endtask

    task automatic model_step(input bit r, input bit l, input logic [31:0] p, input int ln,
                              input bit s, input bit sp, input bit rp);
        exp_t e;
        int tag;
        tag = cyc + 1;
        if (r) begin
            m_busy = 1'b0; m_pat = '0; m_len = 0; m_hist.delete();
        end else if (!m_busy) begin
            if (l) begin
                m_pat = p;
                m_len = (ln > MAX_LEN) ? MAX_LEN : ln;
            end
            if (s && m_len != 0) begin
                build_frame();
                m_busy = 1'b1; m_idx = 0;
                emit(tag);
            end
        end else if (sp) begin
            m_busy = 1'b0;
        end else if (m_idx == m_fbit.size() - 1) begin
            if (rp) begin
                m_idx = 0;
                emit(tag);
            end else begin
                m_busy = 1'b0;
                e.is_done = 1'b1; e.b = 1'b0; e.p = 0; e.pf = 1'b0; e.s6 = '0; e.cyc = tag;
                sb.push_back(e);
            end
        end else begin
            m_idx++;
            emit(tag);
        end
    endtask

    task automatic step(input bit r, input bit l, input logic [31:0] p, input int ln,
                        input bit s, input bit sp, input bit rp);
        rst = r; load = l; pat = p; len = PTR_W'(ln); start = s; stop = sp; repeat_en = rp;
        model_step(r, l, p, ln, s, sp, rp);
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n, input bit rp);
        for (int i = 0; i < n; i++) step(0, 0, 32'h0, 0, 0, 0, rp);
    endtask

    // Monitor: pops an expectation whenever the DUT presents a bit or a done pulse
    exp_t me;
    always @(negedge clk) begin
        if (dvalid || done) begin
            if (sb.size() == 0) begin
                chk(1'b0, "unexpected_output", $sformatf("dvalid=%0b done=%0b cyc=%0d", dvalid, done, cyc), "no output");
            end else begin
                me = sb.pop_front();
                if (me.is_done)
                    chk(done && !dvalid && (cyc == me.cyc), "done_pulse",
                        $sformatf("done=%0b dvalid=%0b cyc=%0d", done, dvalid, cyc),
                        $sformatf("done=1 dvalid=0 cyc=%0d", me.cyc));
                else
                    chk(dvalid && !done && (dout == me.b) && (int'(ptr) == me.p) && (par_flag == me.pf)
                        && (sreg6 == me.s6) && (cyc == me.cyc), "tx_bit",
                        $sformatf("dout=%0b ptr=%0d par=%0b sreg6=%b done=%0b cyc=%0d", dout, ptr, par_flag, sreg6, done, cyc),
                        $sformatf("dout=%0b ptr=%0d par=%0b sreg6=%b done=0 cyc=%0d", me.b, me.p, me.pf, me.s6, me.cyc));
            end
        end else begin
            chk((dout == 1'b0) && (ptr == '0) && (par_flag == 1'b0), "idle_outputs",
                $sformatf("dout=%0b ptr=%0d par=%0b", dout, ptr, par_flag), "dout=0 ptr=0 par=0");
        end
        chk(busy == dvalid, "busy_tracks_dvalid", $sformatf("busy=%0b dvalid=%0b", busy, dvalid), "equal");
    end

    initial begin
        int plen;
        bit r, l, s, sp, rp;
        logic [31:0] p;
        int ln;
`ifdef SEQ_GEN_PARITY_EN
        plen = 9;
`else
        plen = 8;
`endif
        // Reset state
        step(1, 0, 32'h0, 0, 0, 0, 0);
        step(1, 0, 32'h0, 0, 0, 0, 0);
        chk({dout, dvalid, busy, done, ptr, par_flag, sreg6} == '0, "reset_state",
            $sformatf("%b", {dout, dvalid, busy, done, ptr, par_flag, sreg6}), "all zero");

        // Single pass of 0xB2, length 8
        step(0, 1, 32'h0000_00B2, 8, 1, 0, 0);
        idle(plen, 0);
`ifdef SEQ_GEN_PARITY_EN
        chk(done && sreg6 == 6'b011010, "single_pass_end", $sformatf("done=%0b sreg6=%b", done, sreg6), "done=1 sreg6=011010");
`else
        chk(done && sreg6 == 6'b001101, "single_pass_end", $sformatf("done=%0b sreg6=%b", done, sreg6), "done=1 sreg6=001101");
`endif
        idle(2, 0);

        // Seamless repeat, then stop
        step(0, 1, 32'h0000_00B2, 8, 1, 0, 1);
        idle(20, 1);
        step(0, 0, 32'h0, 0, 0, 1, 1);
        idle(2, 0);

        // Stop at ptr 3, then restart from bit 0
        step(0, 1, 32'h0000_00B2, 8, 1, 0, 1);
        idle(3, 1);
        chk(ptr == 6'd3, "ptr_before_stop", $sformatf("%0d", ptr), "3");
        step(0, 0, 32'h0, 0, 0, 1, 1);
        chk(!busy && !dvalid && !done && ptr == '0, "after_stop",
            $sformatf("busy=%0b dvalid=%0b done=%0b ptr=%0d", busy, dvalid, done, ptr), "all zero");
        step(0, 0, 32'h0, 0, 1, 0, 0);
        idle(plen + 1, 0);

        // Zero length start is ignored
        step(0, 1, 32'hFFFF_FFFF, 0, 1, 0, 0);
        chk(!busy && !done, "len0_ignored", $sformatf("busy=%0b done=%0b", busy, done), "busy=0 done=0");
        step(0, 0, 32'h0, 0, 1, 0, 0);
        idle(1, 0);

        // Length 40 clamps to 32
        step(0, 1, $urandom, 40, 1, 0, 0);
        idle(MAX_LEN + 3, 0);

        // Load during RUN does not disturb the pattern
        step(0, 1, 32'h0000_00B2, 8, 1, 0, 0);
        step(0, 1, 32'hFFFF_FFFF, 3, 1, 0, 0);
        idle(plen + 1, 0);

        // Reset mid-run at ptr 5
        step(0, 1, 32'h0000_00B3, 8, 1, 0, 1);
        idle(5, 1);
        chk(ptr == 6'd5, "ptr_before_reset", $sformatf("%0d", ptr), "5");
        step(1, 0, 32'h0, 0, 0, 0, 1);
        chk({dout, dvalid, busy, done, ptr, par_flag, sreg6} == '0, "reset_mid_run",
            $sformatf("%b", {dout, dvalid, busy, done, ptr, par_flag, sreg6}), "all zero");
        idle(3, 1);

        // Single-bit pattern repeating, and 0xB3 parity
        step(0, 1, 32'h0000_0001, 1, 1, 0, 1);
        idle(5, 1);
        step(0, 0, 32'h0, 0, 0, 1, 0);
        step(0, 1, 32'h0000_00B3, 8, 1, 0, 0);
        idle(7, 0);
`ifdef SEQ_GEN_PARITY_EN
        idle(1, 0);
        chk(dout && par_flag && ptr == 6'd7, "parity_b3",
            $sformatf("dout=%0b par=%0b ptr=%0d", dout, par_flag, ptr), "dout=1 par=1 ptr=7");
`endif
        idle(3, 0);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            r  = ($urandom % 64) == 0;
            l  = ($urandom % 4) == 0;
            p  = $urandom;
            ln = ($urandom % 2) ? $urandom_range(0, 4) : $urandom_range(0, 40);
            s  = ($urandom % 4) == 0;
            sp = ($urandom % 16) == 0;
            rp = $urandom % 2;
            step(r, l, p, ln, s, sp, rp);
        end

        // Drain and confirm every expectation was consumed
        idle(MAX_LEN + 6, 0);
        @(negedge clk);
        #1;
        chk(sb.size() == 0, "scoreboard_empty", $sformatf("%0d left", sb.size()), "0 left");
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
